// File: rtl/sr_imem_loader_if.sv
// Byte-stream load port and CPU instruction-fetch port of the imem loader.
interface sr_imem_loader_if;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        cpu_rst;
  logic        busy;
  logic        load_err;

  modport master (
    output load_req, in_valid, in_data, imAddr,
    input  in_ready, imData, cpu_rst, busy, load_err
  );

  modport slave (
    input  load_req, in_valid, in_data, imAddr,
    output in_ready, imData, cpu_rst, busy, load_err
  );
endinterface

// File: rtl/sr_imem_loader.sv
// Loads a length-prefixed little-endian program into instruction memory from
// a byte stream, holding the CPU in reset until the load completes.
module sr_imem_loader #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic clk,
  input logic rst,
  sr_imem_loader_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE = 3'd0, HDR0, HDR1, LOAD, RUN} state_t;

  state_t      state, state_nxt;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic        err;
  logic [31:0] mem [DEPTH];

  logic xfer_c, start_c, word_done_c, last_c, wr_c;

  // Status outputs are pure decodes of the state register, so they cannot glitch.
  assign bus.in_ready = (state == HDR0) || (state == HDR1) || (state == LOAD);
  assign bus.busy     = (state == HDR0) || (state == HDR1) || (state == LOAD);
  assign bus.cpu_rst  = (state != RUN);
  assign bus.load_err = err;

  assign xfer_c      = bus.in_valid && bus.in_ready;
  assign start_c     = bus.load_req && ((state == IDLE) || (state == RUN));
  assign word_done_c = (state == LOAD) && xfer_c && (byte_idx == 2'd3);
  assign last_c      = word_done_c && (word_idx == count - 16'd1);
  assign wr_c        = word_done_c && (32'(word_idx) < DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN: if (start_c) state_nxt = HDR0;
      HDR0:      if (xfer_c)  state_nxt = HDR1;
      HDR1:      if (xfer_c)  state_nxt = ({bus.in_data, count[7:0]} == 16'd0) ? RUN : LOAD;
      LOAD:      if (last_c)  state_nxt = RUN;
      default:   state_nxt = IDLE;
    endcase
  end

  // Header capture, byte assembly and overflow tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      partial  <= '0;
      err      <= 1'b0;
    end else begin
      if (start_c) begin
        err      <= 1'b0;
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (xfer_c) begin
        case (state)
          HDR0: count[7:0] <= bus.in_data;
          HDR1: begin
            count[15:8] <= bus.in_data;
            word_idx    <= '0;
            byte_idx    <= '0;
          end
          LOAD: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    partial[7:0]   <= bus.in_data;
              2'd1:    partial[15:8]  <= bus.in_data;
              2'd2:    partial[23:16] <= bus.in_data;
              default: begin
                word_idx <= word_idx + 16'd1;
                if (!wr_c) err <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Memory is deliberately not reset so a reset never wipes a loaded program.
  always_ff @(posedge clk) begin
    if (wr_c) mem[word_idx[AW-1:0]] <= {bus.in_data, partial};
  end

  assign bus.imData = (bus.imAddr < DEPTH) ? mem[bus.imAddr[AW-1:0]] : NOP_WORD;
endmodule

// File: tb/tb_sr_imem_loader.sv
// Drives one byte stream into a DEPTH=64 and a DEPTH=4 loader in parallel and
// checks both against a word-level model of the loaded program.
module tb_sr_imem_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_imem_loader_if a ();
  sr_imem_loader_if b ();
  assign b.load_req = a.load_req;
  assign b.in_valid = a.in_valid;
  assign b.in_data  = a.in_data;
  assign b.imAddr   = a.imAddr;

  sr_imem_loader #(.DEPTH(64), .NOP_WORD(NOP)) u_dut64 (.clk(clk), .rst(rst), .bus(a));
  sr_imem_loader #(.DEPTH(4),  .NOP_WORD(NOP)) u_dut4  (.clk(clk), .rst(rst), .bus(b));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp4;
    logic [31:0] exp64;
  } rd_vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] m4 [4];
  logic [31:0] m64 [64];
  bit          v4 [4];
  bit          v64 [64];
  bit          e4, e64;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word i of the program lands at address i if it fits, else it flags an overflow.
  task automatic model_load(input logic [31:0] w[$]);
    for (int i = 0; i < w.size(); i++) begin
      if (i < 4)  begin m4[i]  = w[i]; v4[i]  = 1'b1; end
      if (i < 64) begin m64[i] = w[i]; v64[i] = 1'b1; end
    end
    e4  = (w.size() > 4);
    e64 = (w.size() > 64);
  endtask

  task automatic make_stream(input logic [31:0] w[$], output logic [7:0] q[$]);
    int n;
    n = w.size();
    q = {};
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    foreach (w[i])
      for (int k = 0; k < 4; k++) q.push_back(8'(w[i] >> (8 * k)));
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int k;
    repeat (gap) begin
      a.in_valid = 1'b0;
      a.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    a.in_valid = 1'b1;
    a.in_data  = d;
    k = 0;
    while (!a.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 50) chk("byte_accept_timeout", 32'(a.in_ready), 32'd1);
    @(posedge clk); #1;
    a.in_valid = 1'b0;
  endtask

  // Valid is held high with junk data in the request cycle: no byte may be taken.
  task automatic pulse_load_req;
    a.load_req = 1'b1;
    a.in_valid = 1'b1;
    a.in_data  = 8'hAA;
    chk("in_ready_on_req64", 32'(a.in_ready), 32'd0);
    chk("in_ready_on_req4",  32'(b.in_ready), 32'd0);
    @(posedge clk); #1;
    a.load_req = 1'b0;
    a.in_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle plus a 20-cycle gap mid-word, 2: random gaps
  task automatic run_load(input logic [31:0] w[$], input int mode);
    logic [7:0] q[$];
    int gap;
    make_stream(w, q);
    pulse_load_req();
    foreach (q[i]) begin
      if (mode == 0)      gap = 0;
      else if (mode == 1) gap = (i == 4) ? 20 : 1;
      else                gap = int'($urandom_range(2, 0));
      send_byte(q[i], gap);
    end
    model_load(w);
    chk("cpu_rst64_done", 32'(a.cpu_rst), 32'd0);
    chk("cpu_rst4_done",  32'(b.cpu_rst), 32'd0);
    chk("busy64_done",    32'(a.busy),    32'd0);
    chk("busy4_done",     32'(b.busy),    32'd0);
    chk("load_err64",     32'(a.load_err), 32'(e64));
    chk("load_err4",      32'(b.load_err), 32'(e4));
  endtask

  task automatic check_mem(input logic [31:0] addr);
    a.imAddr = addr;
    #1;
    if (addr < 32'd4) begin
      if (v4[addr[1:0]]) chk("imData4", b.imData, m4[addr[1:0]]);
    end else chk("imData4_nop", b.imData, NOP);
    if (addr < 32'd64) begin
      if (v64[addr[5:0]]) chk("imData64", a.imData, m64[addr[5:0]]);
    end else chk("imData64_nop", a.imData, NOP);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cpu_rst64"},  32'(a.cpu_rst),  32'd1);
    chk({tag, "_cpu_rst4"},   32'(b.cpu_rst),  32'd1);
    chk({tag, "_in_ready64"}, 32'(a.in_ready), 32'd0);
    chk({tag, "_in_ready4"},  32'(b.in_ready), 32'd0);
    chk({tag, "_busy64"},     32'(a.busy),     32'd0);
    chk({tag, "_load_err64"}, 32'(a.load_err), 32'd0);
    chk({tag, "_load_err4"},  32'(b.load_err), 32'd0);
  endtask

  initial begin
    rd_vec_t     tbl [8];
    logic [31:0] wv[$];
    logic [31:0] ww[$];

    // Expected reads after the 5-word overflow load of 32'hC0DE_0000 + i*32'h1111.
    tbl[0] = '{32'd0,          32'hC0DE_0000, 32'hC0DE_0000};
    tbl[1] = '{32'd1,          32'hC0DE_1111, 32'hC0DE_1111};
    tbl[2] = '{32'd2,          32'hC0DE_2222, 32'hC0DE_2222};
    tbl[3] = '{32'd3,          32'hC0DE_3333, 32'hC0DE_3333};
    tbl[4] = '{32'd4,          NOP,           32'hC0DE_4444};
    tbl[5] = '{32'd64,         NOP,           NOP};
    tbl[6] = '{32'd1000,       NOP,           NOP};
    tbl[7] = '{32'hFFFF_FFFF,  NOP,           NOP};

    foreach (v4[i])  v4[i]  = 1'b0;
    foreach (v64[i]) v64[i] = 1'b0;
    e4 = 1'b0; e64 = 1'b0;

    rst = 1'b0;
    a.load_req = 1'b0; a.in_valid = 1'b0; a.in_data = '0; a.imAddr = '0;
    #1;
    check_idle("in_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    repeat (10) begin
      @(posedge clk); #1;
      check_idle("post_reset");
    end

    // Two-word program, back-to-back bytes.
    wv = {32'h0010_0513, 32'h0020_0593};
    run_load(wv, 0);
    a.imAddr = 32'd0; #1; chk("prog_w0", a.imData, 32'h0010_0513);
    a.imAddr = 32'd1; #1; chk("prog_w1", a.imData, 32'h0020_0593);

    // Random programs with random input gaps; DEPTH=4 instance overflows often.
    for (int t = 0; t < 6; t++) begin
      ww = {};
      for (int i = 0; i < int'($urandom_range(7, 0)); i++) ww.push_back($urandom);
      run_load(ww, 2);
      for (int ad = 0; ad < 8; ad++) check_mem(32'(ad));
      check_mem(32'h100 | 32'($urandom_range(32'hFFFF, 0)));
      @(posedge clk); #1;
    end

    // Same two-word program with stalls must yield identical contents.
    run_load(wv, 1);
    a.imAddr = 32'd0; #1; chk("stall_w0", b.imData, 32'h0010_0513);
    a.imAddr = 32'd1; #1; chk("stall_w1", b.imData, 32'h0020_0593);
    check_mem(32'd0);
    check_mem(32'd1);

    // Overflow: 5 words into DEPTH=4.
    ww = {};
    for (int i = 0; i < 5; i++) ww.push_back(32'hC0DE_0000 + 32'(i) * 32'h1111);
    run_load(ww, 0);
    chk("ovf_err4",  32'(b.load_err), 32'd1);
    chk("ovf_err64", 32'(a.load_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      a.imAddr = tbl[i].addr;
      #1;
      chk("tbl_imData4",  b.imData, tbl[i].exp4);
      chk("tbl_imData64", a.imData, tbl[i].exp64);
    end

    // Empty program: straight to RUN, memory untouched, stale error cleared.
    ww = {};
    run_load(ww, 0);
    for (int ad = 0; ad < 5; ad++) check_mem(32'(ad));

    // Reset after 6 load bytes; an extra load_req mid-load must be ignored.
    pulse_load_req();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    a.load_req = 1'b1;
    @(posedge clk); #1;
    a.load_req = 1'b0;
    chk("busy_after_ignored_req", 32'(a.busy), 32'd1);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'hF0, 0);
    send_byte(8'hDE, 0);
    chk("busy_mid_load", 32'(a.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_idle("mid_load_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    m4[0] = 32'h1234_5678;
    m64[0] = 32'h1234_5678;
    check_mem(32'd0);
    check_mem(32'd1);
    chk("w1_retained", b.imData, 32'hC0DE_1111);
    @(posedge clk); #1;
    check_idle("after_reset_release");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sr_imem_loader.md
SR_IMEM_LOADER -- requirements
Module: sr_imem_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction memory size in 32-bit words; power of two, at least 4.
REQ-002 Parameter NOP_WORD, default 32'h00000013: word returned for out-of-range fetch addresses.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low (0 = in reset).
REQ-005 load_req  input  1  one-cycle request to start a program load.
REQ-006 in_valid  input  1  load byte valid.
REQ-007 in_data  input  8  load byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 imAddr  input  32  CPU fetch word address (byte PC >> 2).
REQ-010 imData  output  32  instruction word at imAddr, combinational.
REQ-011 cpu_rst  output  1  active-high hold-in-reset for the CPU.
REQ-012 busy  output  1  load in progress.
REQ-013 load_err  output  1  sticky overflow flag for the last load.

Function
REQ-014 States SHALL be IDLE, HDR0, HDR1, LOAD and RUN; the reset state is IDLE.
REQ-015 A byte transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_ready=1 only in HDR0, HDR1 and LOAD.
REQ-016 load_req SHALL be honoured only in IDLE or RUN (go to HDR0, clear load_err); it is ignored in all other states.
REQ-017 In the cycle load_req is honoured, in_ready SHALL be 0, so no byte is taken.
REQ-018 HDR0 SHALL capture the word count bits 7:0 and HDR1 bits 15:8 (16-bit little-endian count N).
REQ-019 On the HDR1 transfer, N=0 SHALL go to RUN; otherwise the loader goes to LOAD with word index 0 and byte index 0.
REQ-020 In LOAD, bytes SHALL be assembled little-endian: byte 0 goes to bits 7:0 and byte 3 to bits 31:24.
REQ-021 The completed word SHALL be written to mem[index] on the clock edge of the 4th byte transfer; index then increments.
REQ-022 Words with index >= DEPTH SHALL be discarded, not written, and SHALL set load_err=1.
REQ-023 LOAD SHALL go to RUN on the edge of the final byte transfer (byte 4N).
REQ-024 Input gaps (in_valid=0) SHALL stall the loader indefinitely with no loss of state.
REQ-025 imData SHALL be mem[imAddr] when imAddr < DEPTH, else NOP_WORD.
REQ-026 imData SHALL be valid in every state.
REQ-027 Reads in a write cycle SHALL return the old contents.
REQ-028 cpu_rst SHALL be 1 in every state except RUN, and SHALL be decoded from the state register only (glitch-free).
REQ-029 busy SHALL be 1 in HDR0, HDR1 and LOAD.
REQ-030 Memory contents SHALL be undefined after power-up; words are overwritten only by loads.

Reset
REQ-031 While rst=0: state=IDLE, cpu_rst=1, in_ready=0, busy=0, load_err=0, counters and partial word cleared.
REQ-032 Memory array SHALL NOT be reset; words written before a reset are retained.
REQ-033 Reset mid-load SHALL discard the partial word and leave completed words intact.

Verification
REQ-034 Reset release, no stimulus -> cpu_rst=1, in_ready=0, busy=0, load_err=0 for 10 cycles.
REQ-035 load_req; bytes 02 00 13 05 10 00 93 05 20 00 back-to-back -> imData@0=0x00100513, imData@1=0x00200593; cpu_rst=0 the cycle after byte 10; busy=0.
REQ-036 Same stream with in_valid toggling every other cycle plus a 20-cycle gap mid-word -> identical memory contents and final state.
REQ-037 DEPTH=4; header 05 00 plus 20 bytes -> load_err=1; words 0-3 written; imAddr=4 and imAddr=1000 return 0x00000013.
REQ-038 Header 00 00 -> RUN right after the HDR1 byte; cpu_rst=0; memory unchanged.
REQ-039 Reset asserted after 6 LOAD bytes of a 2-word load -> IDLE, cpu_rst=1, word 0 retained, word 1 unchanged; a load_req during LOAD is ignored.
